// File: rtl/char_anim_pkg.sv
// Shared encodings for the character animation controller,
// the sprite selector and the game FSM.
package char_anim_pkg;

    typedef enum logic [7:0] {
        ST_STAND  = 8'd0,
        ST_ATTACK = 8'd1,
        ST_MOVEL  = 8'd2,
        ST_MOVER  = 8'd3,
        ST_HURT   = 8'd4,
        ST_DEFEND = 8'd5,
        ST_DIE    = 8'd6
    } char_state_e;

    localparam logic [7:0] DIE_LAST_FRAME = 8'd11;

    // Number of sprite frames stored for each state
    function automatic logic [7:0] frame_count(char_state_e s);
        case (s)
            ST_STAND:  return 8'd8;
            ST_ATTACK: return 8'd9;
            ST_MOVEL:  return 8'd5;
            ST_MOVER:  return 8'd5;
            ST_HURT:   return 8'd4;
            ST_DEFEND: return 8'd1;
            ST_DIE:    return 8'd12;
            default:   return 8'd1;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain
// and turns its rising edge into a one-cycle tick.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

endmodule

// File: rtl/character_anim_ctrl.sv
// Character animation sequencer: picks the sprite state and
// frame index, advancing only on synchronized frame ticks.
module character_anim_ctrl
    import char_anim_pkg::*;
#(
    parameter int TICKS_PER_FRAME  = 4,
    parameter int ATTACK_HIT_FRAME = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       game_active,
    input  logic       restart,
    input  logic       move_l,
    input  logic       move_r,
    input  logic       defend,
    input  logic       attack,
    input  logic       hurt_pulse,
    input  logic       die,
    output logic [7:0] char_state,
    output logic [7:0] frame_num,
    output logic       attack_hit,
    output logic       busy,
    output logic       die_done
);

    localparam logic [7:0] HOLD_LAST = 8'(TICKS_PER_FRAME - 1);
    localparam logic [7:0] HIT_FRAME = 8'(ATTACK_HIT_FRAME);

    logic tick;

    frame_tick_sync u_sync (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    char_state_e state;
    char_state_e nxt_state;
    char_state_e base_st;
    char_state_e tgt;
    logic [7:0]  frame;
    logic [7:0]  nxt_frame;
    logic [7:0]  hold;
    logic [7:0]  nxt_hold;
    logic [7:0]  last;
    logic        attack_q;
    logic        die_p;
    logic        hurt_p;
    logic        atk_p;
    logic        die_eff;
    logic        hurt_eff;
    logic        atk_eff;
    logic        nxt_die_p;
    logic        nxt_hurt_p;
    logic        nxt_atk_p;
    logic        hold_wrap;
    logic        done;
    logic        restart_anim;
    logic        nxt_hit;

    // Next-state, frame, hold and pending-flag computation
    always_comb begin
        die_eff   = die_p | die;
        hurt_eff  = hurt_p | hurt_pulse;
        atk_eff   = atk_p | (attack & ~attack_q);
        last      = frame_count(state) - 8'd1;
        hold_wrap = (hold == HOLD_LAST);
        done      = hold_wrap && (frame == last);
        base_st   = defend ? ST_DEFEND :
                    move_r ? ST_MOVER  :
                    move_l ? ST_MOVEL  : ST_STAND;
        tgt          = state;
        restart_anim = 1'b0;
        nxt_state  = state;
        nxt_frame  = frame;
        nxt_hold   = hold;
        nxt_die_p  = die_eff;
        nxt_hurt_p = hurt_eff;
        nxt_atk_p  = atk_eff;
        if (restart) begin
            nxt_state  = ST_STAND;
            nxt_frame  = 8'd0;
            nxt_hold   = 8'd0;
            nxt_die_p  = 1'b0;
            nxt_hurt_p = 1'b0;
            nxt_atk_p  = 1'b0;
        end else if (tick) begin
            nxt_die_p  = 1'b0;
            nxt_hurt_p = 1'b0;
            nxt_atk_p  = 1'b0;
            if (!game_active) begin
                nxt_state = ST_STAND;
                nxt_frame = 8'd0;
                nxt_hold  = 8'd0;
            end else if (state == ST_DIE) begin
                if (frame == last) begin
                    nxt_hold = 8'd0;
                end else if (hold_wrap) begin
                    nxt_hold  = 8'd0;
                    nxt_frame = frame + 8'd1;
                end else begin
                    nxt_hold = hold + 8'd1;
                end
            end else begin
                if (die_eff)
                    tgt = ST_DIE;
                else if (hurt_eff)
                    tgt = ST_HURT;
                else if (state == ST_ATTACK || state == ST_HURT)
                    tgt = done ? base_st : state;
                else
                    tgt = atk_eff ? ST_ATTACK : base_st;
                restart_anim = (tgt != state) ||
                               (hurt_eff && state == ST_HURT);
                nxt_state = tgt;
                if (restart_anim) begin
                    nxt_frame = 8'd0;
                    nxt_hold  = 8'd0;
                end else if (hold_wrap) begin
                    nxt_hold  = 8'd0;
                    nxt_frame = (frame == last) ? 8'd0 : frame + 8'd1;
                end else begin
                    nxt_hold = hold + 8'd1;
                end
            end
        end
        nxt_hit = tick && !restart &&
                  nxt_state == ST_ATTACK &&
                  nxt_frame == HIT_FRAME &&
                  !(state == ST_ATTACK && frame == HIT_FRAME);
    end

    // State, counters, pending flags and registered status outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_STAND;
            frame      <= 8'd0;
            hold       <= 8'd0;
            attack_q   <= 1'b0;
            die_p      <= 1'b0;
            hurt_p     <= 1'b0;
            atk_p      <= 1'b0;
            attack_hit <= 1'b0;
            busy       <= 1'b0;
            die_done   <= 1'b0;
        end else begin
            state      <= nxt_state;
            frame      <= nxt_frame;
            hold       <= nxt_hold;
            attack_q   <= attack;
            die_p      <= nxt_die_p;
            hurt_p     <= nxt_hurt_p;
            atk_p      <= nxt_atk_p;
            attack_hit <= nxt_hit;
            busy       <= (nxt_state == ST_ATTACK) ||
                          (nxt_state == ST_HURT);
            die_done   <= (nxt_state == ST_DIE) &&
                          (nxt_frame == DIE_LAST_FRAME);
        end
    end

    assign char_state = state;
    assign frame_num  = frame;

endmodule

// File: tb/tb_character_anim_ctrl.sv
// Directed bench for character_anim_ctrl: vector table plus
// hand-written sequences for hurt, die, restart and reset.
module tb_character_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       game_active = 1'b1;
    logic       restart = 1'b0;
    logic       move_l = 1'b0;
    logic       move_r = 1'b0;
    logic       defend = 1'b0;
    logic       attack = 1'b0;
    logic       hurt_pulse = 1'b0;
    logic       die = 1'b0;
    logic [7:0] char_state;
    logic [7:0] frame_num;
    logic       attack_hit;
    logic       busy;
    logic       die_done;
    logic [7:0] char_state2;
    logic [7:0] frame_num2;
    logic       attack_hit2;
    logic       busy2;
    logic       die_done2;

    int npass = 0;
    int ntotal = 0;
    int hits = 0;
    int hits2 = 0;
    logic [7:0] hit_frame = 8'hFF;

    always #10 Clk = ~Clk;

    character_anim_ctrl #(.TICKS_PER_FRAME(1), .ATTACK_HIT_FRAME(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .game_active(game_active), .restart(restart),
        .move_l(move_l), .move_r(move_r), .defend(defend),
        .attack(attack), .hurt_pulse(hurt_pulse), .die(die),
        .char_state(char_state), .frame_num(frame_num),
        .attack_hit(attack_hit), .busy(busy), .die_done(die_done)
    );

    character_anim_ctrl #(.TICKS_PER_FRAME(2), .ATTACK_HIT_FRAME(4)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .game_active(game_active), .restart(restart),
        .move_l(move_l), .move_r(move_r), .defend(defend),
        .attack(attack), .hurt_pulse(hurt_pulse), .die(die),
        .char_state(char_state2), .frame_num(frame_num2),
        .attack_hit(attack_hit2), .busy(busy2), .die_done(die_done2)
    );

    // Count hit pulses away from the active edge
    always @(negedge Clk) begin
        if (attack_hit) begin
            hits = hits + 1;
            hit_frame = frame_num;
        end
        if (attack_hit2)
            hits2 = hits2 + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        ntotal = ntotal + 1;
        if (act == exp)
            npass = npass + 1;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One frame strobe; state has updated when this returns
    task automatic do_tick();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic pulse(input int which);
        @(negedge Clk);
        if (which == 0) hurt_pulse = 1'b1;
        if (which == 1) die = 1'b1;
        if (which == 2) restart = 1'b1;
        @(negedge Clk);
        hurt_pulse = 1'b0;
        die = 1'b0;
        restart = 1'b0;
    endtask

    typedef struct {
        logic       ml;
        logic       mr;
        logic       df;
        logic       at;
        logic [7:0] st;
        logic [7:0] fr;
        logic       bz;
    } vec_t;

    vec_t tv[$];

    initial begin
        int h0;
        // stand loop: 10 ticks from frame 0
        for (int i = 0; i < 10; i++)
            tv.push_back('{0, 0, 0, 0, 8'd0, 8'((i + 1) % 8), 0});
        tv.push_back('{0, 1, 0, 0, 8'd3, 8'd0, 0});
        tv.push_back('{0, 1, 0, 0, 8'd3, 8'd1, 0});
        tv.push_back('{1, 1, 0, 0, 8'd3, 8'd2, 0});
        tv.push_back('{1, 0, 0, 0, 8'd2, 8'd0, 0});
        tv.push_back('{1, 0, 1, 0, 8'd5, 8'd0, 0});
        tv.push_back('{0, 0, 1, 0, 8'd5, 8'd0, 0});
        tv.push_back('{0, 0, 0, 0, 8'd0, 8'd0, 0});
        tv.push_back('{0, 0, 0, 1, 8'd1, 8'd0, 1});
        for (int i = 1; i <= 8; i++)
            tv.push_back('{0, 1, 1, 1, 8'd1, 8'(i), 1});
        tv.push_back('{0, 0, 0, 0, 8'd0, 8'd0, 0});

        repeat (3) @(negedge Clk);
        chk("reset_state", int'(char_state), 0);
        chk("reset_frame", int'(frame_num), 0);
        chk("reset_busy", int'(busy), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        foreach (tv[i]) begin
            move_l = tv[i].ml;
            move_r = tv[i].mr;
            defend = tv[i].df;
            attack = tv[i].at;
            do_tick();
            chk($sformatf("vec%0d_state", i), int'(char_state), int'(tv[i].st));
            chk($sformatf("vec%0d_frame", i), int'(frame_num), int'(tv[i].fr));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tv[i].bz));
        end
        chk("attack_hit_count", hits, 1);
        chk("attack_hit_frame", int'(hit_frame), 4);

        // hurt pre-empts attack at frame 3
        h0 = hits;
        attack = 1'b1;
        for (int i = 0; i < 4; i++) do_tick();
        chk("pre_hurt_frame", int'(frame_num), 3);
        pulse(0);
        do_tick();
        chk("hurt_state", int'(char_state), 4);
        chk("hurt_frame", int'(frame_num), 0);
        chk("hurt_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) do_tick();
        chk("hurt_last_frame", int'(frame_num), 3);
        do_tick();
        chk("hurt_to_stand", int'(char_state), 0);
        chk("hurt_no_hit", hits - h0, 0);
        attack = 1'b0;

        // die plays 12 frames then holds the last one
        pulse(1);
        move_r = 1'b1;
        for (int i = 0; i < 15; i++) begin
            do_tick();
            chk($sformatf("die%0d_state", i), int'(char_state), 6);
            chk($sformatf("die%0d_frame", i), int'(frame_num), (i < 11) ? i : 11);
            chk($sformatf("die%0d_done", i), int'(die_done), (i >= 11) ? 1 : 0);
        end
        pulse(2);
        chk("die_restart_state", int'(char_state), 0);
        chk("die_restart_frame", int'(frame_num), 0);
        chk("die_restart_done", int'(die_done), 0);

        // restart coinciding with a tick wins
        do_tick();
        do_tick();
        chk("pre_rs_state", int'(char_state), 3);
        chk("pre_rs_frame", int'(frame_num), 1);
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        chk("rs_tick_state", int'(char_state), 0);
        chk("rs_tick_frame", int'(frame_num), 0);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
        move_r = 1'b0;

        // asynchronous reset in the middle of an attack
        attack = 1'b1;
        for (int i = 0; i < 3; i++) do_tick();
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_frame", int'(frame_num), 2);
        #5 Reset_n = 1'b0;
        #1;
        chk("rst_state", int'(char_state), 0);
        chk("rst_frame", int'(frame_num), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_hit", int'(attack_hit), 0);
        @(negedge Clk);
        attack = 1'b0;
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // game_active low forces stand and drops pending flags
        move_r = 1'b1;
        do_tick();
        chk("ga_move_state", int'(char_state), 3);
        move_r = 1'b0;
        pulse(0);
        game_active = 1'b0;
        do_tick();
        chk("ga_off_state", int'(char_state), 0);
        chk("ga_off_frame", int'(frame_num), 0);
        game_active = 1'b1;
        do_tick();
        chk("ga_flag_cleared", int'(char_state), 0);

        // two ticks per frame: hit still fires exactly once
        pulse(2);
        h0 = hits2;
        attack = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            do_tick();
            if (i == 2) chk("t2_hold_frame", int'(frame_num2), 0);
            if (i == 3) chk("t2_adv_frame", int'(frame_num2), 1);
            if (i == 17) begin
                chk("t2_last_state", int'(char_state2), 1);
                chk("t2_last_frame", int'(frame_num2), 8);
            end
        end
        chk("t2_end_state", int'(char_state2), 0);
        chk("t2_hit_count", hits2 - h0, 1);
        attack = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
